// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller owning mtvec/mepc/mcause/mtval and redirecting fetch on trap or MRET.
// Latency: event sampled at edge N -> one-cycle redirect/flush pulse in cycle N+1; CSR reads are combinational.
// Backpressure: none; all events and CSR writes are ignored while the pulse is active. TRAP_MTVAL_EN enables mtval.
`ifndef XLEN
`define XLEN 32
`endif

module trap_ctrl #(
  parameter logic [`XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifetch_exc_valid,
  input  logic [3:0]       ifetch_exc_cause,
  input  logic [`XLEN-1:0] ifetch_exc_pc,
  input  logic [`XLEN-1:0] ifetch_exc_tval,
  input  logic             exec_exc_valid,
  input  logic [3:0]       exec_exc_cause,
  input  logic [`XLEN-1:0] exec_exc_pc,
  input  logic [`XLEN-1:0] exec_exc_tval,
  input  logic             exec_mret,
  input  logic [11:0]      csr_addr,
  input  logic             csr_write,
  input  logic [`XLEN-1:0] csr_wdata,
  output logic             csr_hit,
  output logic [`XLEN-1:0] csr_rdata,
  output logic             redirect_valid,
  output logic [`XLEN-1:0] redirect_pc,
  output logic             flush
);
  localparam int W = `XLEN;

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;

  typedef enum logic {IDLE, REDIRECT} state_t;
  state_t state;

  logic [W-1:0] mtvec, mepc, mcause, mtval;

  // Event decode: exec is older than ifetch, so it wins; nothing is taken while redirecting.
  logic idle, ev_exec, ev_mret, ev_ifetch, ev_trap, csr_commit;
  logic wr_mtvec, wr_mepc, wr_mcause, wr_mtval;
  logic [3:0]   trap_cause;
  logic [W-1:0] trap_pc, trap_tval, mtvec_fwd, wdata_aligned;

  assign idle      = (state == IDLE);
  assign ev_exec   = idle & exec_exc_valid;
  assign ev_mret   = idle & ~exec_exc_valid & exec_mret;
  assign ev_ifetch = idle & ~exec_exc_valid & ~exec_mret & ifetch_exc_valid;
  assign ev_trap   = ev_exec | ev_ifetch;

  // The CSR write belongs to the exec-stage instruction: it is lost when that
  // instruction traps or is the MRET, but it is older than an ifetch fault.
  assign csr_commit = idle & csr_write & ~ev_exec & ~ev_mret;
  assign wr_mtvec   = csr_commit & (csr_addr == ADDR_MTVEC);
  assign wr_mepc    = csr_commit & (csr_addr == ADDR_MEPC);
  assign wr_mcause  = csr_commit & (csr_addr == ADDR_MCAUSE);
  assign wr_mtval   = csr_commit & (csr_addr == ADDR_MTVAL);

  assign trap_cause    = ev_exec ? exec_exc_cause : ifetch_exc_cause;
  assign trap_pc       = ev_exec ? exec_exc_pc    : ifetch_exc_pc;
  assign trap_tval     = ev_exec ? exec_exc_tval  : ifetch_exc_tval;
  assign wdata_aligned = {csr_wdata[W-1:2], 2'b00};

  // A same-cycle mtvec write lands before an ifetch trap, so the handler address uses it.
  assign mtvec_fwd = wr_mtvec ? wdata_aligned : mtvec;

  // mtvec: direct mode only, mode bits always zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mtvec <= {RESET_MTVEC[W-1:2], 2'b00};
    end else if (wr_mtvec) begin
      mtvec <= wdata_aligned;
    end
  end

  // mepc/mcause: a trap overrides any same-cycle software write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mepc   <= '0;
      mcause <= '0;
    end else if (ev_trap) begin
      mepc   <= {trap_pc[W-1:2], 2'b00};
      mcause <= {{(W-4){1'b0}}, trap_cause};
    end else begin
      if (wr_mepc)   mepc   <= wdata_aligned;
      if (wr_mcause) mcause <= csr_wdata;
    end
  end

`ifdef TRAP_MTVAL_EN
  // mtval: captures the faulting value on a trap, otherwise software-writable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mtval <= '0;
    end else if (ev_trap) begin
      mtval <= trap_tval;
    end else if (wr_mtval) begin
      mtval <= csr_wdata;
    end
  end
`else
  // mtval is hardwired to zero; the address still decodes as present.
  logic unused_mtval;
  assign unused_mtval = ^{trap_tval, wr_mtval};
  assign mtval        = '0;
`endif

  // Redirect FSM: one registered pulse per accepted event, then back to IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ev_trap || ev_mret) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
            redirect_pc    <= ev_mret ? mepc : mtvec_fwd;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
          redirect_pc    <= '0;
        end
      endcase
    end
  end

  // CSR read port, combinational from the address.
  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MTVEC:  csr_rdata = mtvec;
      ADDR_MEPC:   csr_rdata = mepc;
      ADDR_MCAUSE: csr_rdata = mcause;
      ADDR_MTVAL:  csr_rdata = mtval;
      default:     csr_hit   = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven stimulus for trap_ctrl with a redirect scoreboard.
// Latency: expects one redirect pulse in the cycle after each accepted event.
// Backpressure: events are spaced so none land in the redirect cycle except where that is the point.
module tb_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        ifetch_exc_valid;
  logic [3:0]  ifetch_exc_cause;
  logic [31:0] ifetch_exc_pc, ifetch_exc_tval;
  logic        exec_exc_valid;
  logic [3:0]  exec_exc_cause;
  logic [31:0] exec_exc_pc, exec_exc_tval;
  logic        exec_mret;
  logic [11:0] csr_addr;
  logic        csr_write;
  logic [31:0] csr_wdata;
  logic        csr_hit;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  always #5 clk = ~clk;

  trap_ctrl #(.RESET_MTVEC(32'h103)) dut (
    .clk(clk), .rst(rst),
    .ifetch_exc_valid(ifetch_exc_valid), .ifetch_exc_cause(ifetch_exc_cause),
    .ifetch_exc_pc(ifetch_exc_pc), .ifetch_exc_tval(ifetch_exc_tval),
    .exec_exc_valid(exec_exc_valid), .exec_exc_cause(exec_exc_cause),
    .exec_exc_pc(exec_exc_pc), .exec_exc_tval(exec_exc_tval),
    .exec_mret(exec_mret), .csr_addr(csr_addr), .csr_write(csr_write),
    .csr_wdata(csr_wdata), .csr_hit(csr_hit), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
  );

`ifdef TRAP_MTVAL_EN
  localparam bit MTVAL_ON = 1'b1;
`else
  localparam bit MTVAL_ON = 1'b0;
`endif

  function automatic logic [31:0] mtv(input logic [31:0] x);
    return MTVAL_ON ? x : 32'h0;
  endfunction

  typedef struct {
    string       name;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        ifv;
    logic [3:0]  ifc;
    logic [31:0] ifpc, iftval;
    logic        exv;
    logic [3:0]  exc;
    logic [31:0] expc, extval;
    logic        mret;
    logic        exp_redir;
    logic [31:0] exp_pc;
    logic [11:0] rd_addr;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t rd(input string nm, input logic [11:0] a, input logic [31:0] e, input logic h);
    vec_t v;
    v.name = nm; v.wr = 0; v.addr = 0; v.wdata = 0;
    v.ifv = 0; v.ifc = 0; v.ifpc = 0; v.iftval = 0;
    v.exv = 0; v.exc = 0; v.expc = 0; v.extval = 0; v.mret = 0;
    v.exp_redir = 0; v.exp_pc = 0;
    v.rd_addr = a; v.exp_rd = e; v.exp_hit = h;
    return v;
  endfunction

  task automatic clear_inputs();
    ifetch_exc_valid = 0; ifetch_exc_cause = 0; ifetch_exc_pc = 0; ifetch_exc_tval = 0;
    exec_exc_valid = 0; exec_exc_cause = 0; exec_exc_pc = 0; exec_exc_tval = 0;
    exec_mret = 0; csr_write = 0; csr_wdata = 0; csr_addr = 0;
  endtask

  task automatic read_chk(input string nm, input logic [11:0] a, input logic [31:0] e);
    csr_addr = a;
    #1;
    chk(nm, csr_rdata, e);
  endtask

  task automatic apply_vec(input vec_t v);
    @(posedge clk); #2;
    csr_write = v.wr; csr_addr = v.addr; csr_wdata = v.wdata;
    ifetch_exc_valid = v.ifv; ifetch_exc_cause = v.ifc;
    ifetch_exc_pc = v.ifpc; ifetch_exc_tval = v.iftval;
    exec_exc_valid = v.exv; exec_exc_cause = v.exc;
    exec_exc_pc = v.expc; exec_exc_tval = v.extval;
    exec_mret = v.mret;
    if (v.exp_redir) exp_q.push_back(v.exp_pc);
    @(posedge clk); #2;
    clear_inputs();
    csr_addr = v.rd_addr;
    #1;
    chk({v.name, "_rdata"}, csr_rdata, v.exp_rd);
    chk({v.name, "_hit"}, {31'b0, csr_hit}, {31'b0, v.exp_hit});
    @(posedge clk); #1;
    if (v.exp_redir) chk({v.name, "_redirect_missing"}, exp_q.size(), 0);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;

    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    read_chk("rst_mtvec", 12'h305, 32'h100);
    read_chk("rst_mepc", 12'h341, 0);
    read_chk("rst_mcause", 12'h342, 0);
    read_chk("rst_mtval", 12'h343, 0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Scoreboard monitor: every pulse must match the oldest queued target.
    fork
      forever begin
        @(negedge clk);
        if (mon_en && (redirect_valid || flush)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_redirect: valid=%0b flush=%0b pc=%h, expected no pulse",
                     redirect_valid, flush, redirect_pc);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("redirect_pc", redirect_pc, e);
            chk("redirect_valid", {31'b0, redirect_valid}, 1);
            chk("flush", {31'b0, flush}, 1);
          end
        end
      end
    join_none

    v = rd("wr_mtvec", 12'h305, 32'h0C, 1); v.wr = 1; v.addr = 12'h305; v.wdata = 32'h0E; vecs.push_back(v);
    v = rd("ifetch_trap", 12'h341, 32'h04, 1);
    v.ifv = 1; v.ifc = 4'd2; v.ifpc = 32'h04; v.iftval = 32'hFFF0A17F;
    v.exp_redir = 1; v.exp_pc = 32'h0C; vecs.push_back(v);
    vecs.push_back(rd("rd_mcause", 12'h342, 32'h2, 1));
    vecs.push_back(rd("rd_mtval", 12'h343, mtv(32'hFFF0A17F), 1));
    v = rd("exec_wins", 12'h341, 32'h14, 1);
    v.exv = 1; v.exc = 4'd2; v.expc = 32'h14; v.extval = 32'hF11FD073;
    v.ifv = 1; v.ifc = 4'd1; v.ifpc = 32'h40; v.iftval = 32'hAA;
    v.exp_redir = 1; v.exp_pc = 32'h0C; vecs.push_back(v);
    vecs.push_back(rd("rd_mtval_exec", 12'h343, mtv(32'hF11FD073), 1));
    v = rd("wr_mepc", 12'h341, 32'h3C, 1); v.wr = 1; v.addr = 12'h341; v.wdata = 32'h3C; vecs.push_back(v);
    v = rd("mret", 12'h341, 32'h3C, 1); v.mret = 1; v.exp_redir = 1; v.exp_pc = 32'h3C; vecs.push_back(v);
    v = rd("wr_mepc_align", 12'h341, 32'h3C, 1); v.wr = 1; v.addr = 12'h341; v.wdata = 32'h3F; vecs.push_back(v);
    v = rd("ifetch_fwd_mtvec", 12'h305, 32'h1C, 1);
    v.wr = 1; v.addr = 12'h305; v.wdata = 32'h1F;
    v.ifv = 1; v.ifc = 4'd1; v.ifpc = 32'h22; v.iftval = 32'h5;
    v.exp_redir = 1; v.exp_pc = 32'h1C; vecs.push_back(v);
    vecs.push_back(rd("rd_mepc_aligned", 12'h341, 32'h20, 1));
    v = rd("exec_drops_wr", 12'h305, 32'h1C, 1);
    v.wr = 1; v.addr = 12'h305; v.wdata = 32'h80;
    v.exv = 1; v.exc = 4'd3; v.expc = 32'h08; v.extval = 32'h0;
    v.exp_redir = 1; v.exp_pc = 32'h1C; vecs.push_back(v);
    v = rd("wr_mcause", 12'h342, 32'hDEADBEEF, 1); v.wr = 1; v.addr = 12'h342; v.wdata = 32'hDEADBEEF; vecs.push_back(v);
    v = rd("wr_mtval", 12'h343, mtv(32'h1234), 1); v.wr = 1; v.addr = 12'h343; v.wdata = 32'h1234; vecs.push_back(v);
    v = rd("wr_nonhit", 12'h300, 32'h0, 0); v.wr = 1; v.addr = 12'h300; v.wdata = 32'h5; vecs.push_back(v);
    v = rd("ifetch_over_mepc_wr", 12'h341, 32'h50, 1);
    v.wr = 1; v.addr = 12'h341; v.wdata = 32'h99;
    v.ifv = 1; v.ifc = 4'd2; v.ifpc = 32'h50; v.iftval = 32'h1234;
    v.exp_redir = 1; v.exp_pc = 32'h1C; vecs.push_back(v);
    vecs.push_back(rd("rd_mtval_1234", 12'h343, mtv(32'h1234), 1));
    v = rd("mret_drops_wr", 12'h341, 32'h50, 1);
    v.wr = 1; v.addr = 12'h341; v.wdata = 32'h64; v.mret = 1;
    v.exp_redir = 1; v.exp_pc = 32'h50; vecs.push_back(v);
    v = rd("exec_over_mret", 12'h342, 32'hF, 1);
    v.exv = 1; v.exc = 4'hF; v.expc = 32'hA0; v.extval = 32'h7; v.mret = 1;
    v.exp_redir = 1; v.exp_pc = 32'h1C; vecs.push_back(v);
    vecs.push_back(rd("rd_mepc_exec", 12'h341, 32'hA0, 1));

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Inputs held through the redirect cycle must be ignored.
    @(posedge clk); #2;
    ifetch_exc_valid = 1; ifetch_exc_cause = 4'd1; ifetch_exc_pc = 32'h70; ifetch_exc_tval = 32'h77;
    exp_q.push_back(32'h1C);
    @(posedge clk); #2;
    ifetch_exc_pc = 32'h74; exec_exc_valid = 1; exec_exc_pc = 32'h78; exec_mret = 1;
    csr_write = 1; csr_addr = 12'h305; csr_wdata = 32'h200;
    @(posedge clk); #2;
    clear_inputs();
    read_chk("hold_mepc", 12'h341, 32'h70);
    read_chk("hold_mtvec", 12'h305, 32'h1C);
    read_chk("hold_mcause", 12'h342, 32'h1);
    @(posedge clk); #1;
    chk("hold_redirect_missing", exp_q.size(), 0);

    // Reset during REDIRECT cancels the pulse and restores reset values.
    @(posedge clk); #2;
    exec_exc_valid = 1; exec_exc_cause = 4'd5; exec_exc_pc = 32'h90; exec_exc_tval = 32'h9;
    exp_q.push_back(32'h1C);
    @(posedge clk); #2;
    clear_inputs();
    rst = 1'b0;
    @(posedge clk); #3;
    chk("midrst_redirect_valid", {31'b0, redirect_valid}, 0);
    chk("midrst_flush", {31'b0, flush}, 0);
    chk("midrst_redirect_pc", redirect_pc, 0);
    read_chk("midrst_mtvec", 12'h305, 32'h100);
    read_chk("midrst_mepc", 12'h341, 0);
    read_chk("midrst_mcause", 12'h342, 0);
    read_chk("midrst_mtval", 12'h343, 0);
    chk("midrst_pulse_seen", exp_q.size(), 0);
    rst = 1'b1;

    // First trap after reset goes to the reset handler base.
    v = rd("post_rst_trap", 12'h341, 32'h04, 1);
    v.ifv = 1; v.ifc = 4'd2; v.ifpc = 32'h06; v.iftval = 32'h1;
    v.exp_redir = 1; v.exp_pc = 32'h100;
    apply_vec(v);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap controller for the bubbly core, sitting between the ifetch/exec stages and the PC/fetch redirect logic. It accepts synchronous exception reports from ifetch and exec and MRET from exec. It owns the mtvec/mepc/mcause/mtval CSRs, exposes them to the exec CSR port, and issues a one-cycle redirect plus pipeline flush to the trap handler or to mepc.

## Interface
Parameters:
- RESET_MTVEC, 'h0, mtvec value loaded at reset (bits [1:0] forced to 0)

Ports (width W = `XLEN from params.svh):
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- ifetch_exc_valid  in  1  ifetch reports an exception (e.g. illegal/overlong encoding)
- ifetch_exc_cause  in  4  cause code (trap_causes enum value)
- ifetch_exc_pc  in  W  PC of faulting instruction
- ifetch_exc_tval  in  W  trap value (faulting instruction bits)
- exec_exc_valid  in  1  exec reports an exception (e.g. write to read-only CSR)
- exec_exc_cause  in  4  cause code
- exec_exc_pc  in  W  PC of faulting instruction
- exec_exc_tval  in  W  trap value
- exec_mret  in  1  exec retires an MRET
- csr_addr  in  12  CSR address from exec
- csr_write  in  1  commit csr_wdata to csr_addr this cycle
- csr_wdata  in  W  write data
- csr_hit  out  1  csr_addr is mtvec 'h305, mepc 'h341, mcause 'h342 or mtval 'h343
- csr_rdata  out  W  read data, combinational from csr_addr; 0 when no hit
- redirect_valid  out  1  one-cycle pulse, fetch must restart at redirect_pc
- redirect_pc  out  W  target PC
- flush  out  1  kill all in-flight instructions; high exactly when redirect_valid is high

## Operation
- States: IDLE, REDIRECT.
- IDLE, event priority: exec_exc_valid > exec_mret > ifetch_exc_valid (exec is older in program order).
- Exec exception: mepc <= exec_exc_pc & ~3; mcause <= zero-extended cause, bit W-1 = 0; mtval <= exec_exc_tval; target = mtvec base. A csr_write in the same cycle is dropped.
- MRET: target = mepc. CSRs unchanged. A same-cycle csr_write to mepc is dropped.
- Ifetch exception: same CSR updates using the ifetch_* fields. A same-cycle csr_write commits first (it belongs to an older instruction). A write to mtvec is forwarded, so the target uses the new base. A write to mepc/mcause/mtval is overwritten by the trap.
- Any event moves IDLE -> REDIRECT. REDIRECT drives redirect_valid=flush=1 and redirect_pc=target, then returns to IDLE unconditionally.
- In REDIRECT, all exception, MRET and csr_write inputs are ignored; they belong to flushed instructions.
- CSR writes in IDLE with no event commit at the clock edge.
  - mtvec: direct mode only; bits [1:0] WARL, always stored/read as 0 (write 'h0E reads 'h0C).
  - mepc: bits [1:0] stored as 0.
  - mcause: written as-is.
  - mtval: written as-is.
- Writes to non-hit addresses are ignored.

## Timing
- Event sampled at posedge N. CSRs updated at that edge. redirect_valid/flush/redirect_pc valid during cycle N+1 only.
- Back-to-back events: minimum spacing is 2 cycles. The next event can be accepted at posedge N+1 only from IDLE, i.e. never while REDIRECT is active.
- csr_rdata reflects a write from the following cycle onward.
- Reset (rst=0 at posedge): state IDLE; redirect_valid=0, flush=0, redirect_pc=0; mtvec=RESET_MTVEC&~3; mepc, mcause, mtval=0. Reset during REDIRECT cancels the pulse on the next cycle.

## Configuration
- TRAP_MTVAL_EN defined: mtval is implemented as above.
- Not defined: mtval is hardwired 0. Writes are ignored, trap updates are skipped, and 'h343 still hits (reads 0).

## Test plan
- Write mtvec='h0E, then ifetch_exc_valid with pc='h04, cause=EXC_ILLEGAL_INSTR, tval='hFFF0A17F -> next cycle redirect_valid=flush=1, redirect_pc='h0C; mepc='h04, mcause=2, mtval='hFFF0A17F.
- exec_exc_valid (pc='h14, tval='hF11FD073) and ifetch_exc_valid together -> exec wins: mepc='h14, mtval='hF11FD073, exactly one redirect pulse.
- Write mepc='h3C, then exec_mret -> redirect_pc='h3C; mepc unchanged; mepc write of 'h3F reads back 'h3C.
- Same cycle: csr_write mtvec='h1F plus ifetch exception -> redirect_pc='h1C. Same cycle: exec exception plus csr_write mtvec -> mtvec unchanged.
- Exception inputs held high during REDIRECT -> ignored; rst=0 mid-REDIRECT -> all outputs 0 next cycle, CSRs at reset values.
- Without TRAP_MTVAL_EN: trap with tval='h1234 -> mtval reads 0; csr_hit=1 for 'h343.
